// File: rtl/p_stream.sv
// rtl/p_stream.sv - two-stage flow-controlled unary/thermometer-code classifier with statistics
module p_stream #(
   parameter int   W                     = 16,
   parameter logic P_ADMIT_COMPLIMENT_EN = 1'b1,
   parameter logic P_ADMIT_ZERO_EN       = 1'b0,
   parameter int   P_CNT_W               = 16,
   localparam int  NW                    = $clog2(W)
) (
   input  logic               i_clk,
   input  logic               i_arst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [W-1:0]       i_x,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_is_unary,
   output logic               o_is_compliment,
   output logic [NW-1:0]      o_n,
   input  logic               i_cnt_clr,
   output logic [P_CNT_W-1:0] o_accept_cnt,
   output logic [P_CNT_W-1:0] o_reject_cnt
);

   logic               r_s1_valid;
   logic [W-1:0]       r_s1_x;
   logic               r_valid;
   logic               r_unary;
   logic               r_comp;
   logic [NW-1:0]      r_n;
   logic [P_CNT_W-1:0] r_acc;
   logic [P_CNT_W-1:0] r_rej;

   logic               w_adv1;
   logic               w_adv2;
   logic               w_xfer;
   logic               w_m;
   logic [W-1:0]       w_xn;
   logic [W-1:0]       w_xn_inc;
   logic               w_code;
   logic               w_adm;
   logic [NW-1:0]      w_len;

   assign w_adv2 = ~r_valid | i_ready;
   assign w_adv1 = ~r_s1_valid | w_adv2;
   assign w_xfer = r_valid & i_ready;

   // After normalisation the MSB is always 0, so xn+1 never overflows W bits.
   assign w_m      = r_s1_x[W-1];
   assign w_xn     = w_m ? ~r_s1_x : r_s1_x;
   assign w_xn_inc = w_xn + W'(1);
   assign w_code   = ((w_xn & w_xn_inc) == '0);

   always_comb begin
      w_len = '0;
      for (int i = 0; i < W; i++) begin
         w_len = w_len + NW'(w_xn[i]);
      end
   end

   assign w_adm = w_code & (~w_m | P_ADMIT_COMPLIMENT_EN) & ((w_len != '0) | P_ADMIT_ZERO_EN);

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_s1_valid <= 1'b0;
         r_s1_x     <= '0;
         r_valid    <= 1'b0;
         r_unary    <= 1'b0;
         r_comp     <= 1'b0;
         r_n        <= '0;
      end else begin
         if (w_adv1) begin
            r_s1_valid <= i_valid;
            r_s1_x     <= i_x;
         end
         if (w_adv2) begin
            r_valid <= r_s1_valid;
            r_unary <= r_s1_valid & w_adm;
            r_comp  <= r_s1_valid & w_adm & w_m;
            r_n     <= (r_s1_valid & w_adm) ? w_len : '0;
         end
      end
   end

   // Clear takes priority so a transfer coinciding with it is dropped from the statistics.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_acc <= '0;
         r_rej <= '0;
      end else if (i_cnt_clr) begin
         r_acc <= '0;
         r_rej <= '0;
      end else if (w_xfer) begin
         if (r_unary) begin
            if (r_acc != '1) r_acc <= r_acc + P_CNT_W'(1);
         end else begin
            if (r_rej != '1) r_rej <= r_rej + P_CNT_W'(1);
         end
      end
   end

   assign o_ready         = w_adv1;
   assign o_valid         = r_valid;
   assign o_is_unary      = r_unary;
   assign o_is_compliment = r_comp;
   assign o_n             = r_n;
   assign o_accept_cnt    = r_acc;
   assign o_reject_cnt    = r_rej;

endmodule

// File: tb/tb_p_stream.sv
// tb/tb_p_stream.sv - randomized and directed checks of p_stream against a classification model
module tb_p_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Returns {unary, comp, 3'b0, n[3:0]} packed as bit8=unary, bit7=comp, bits3:0=n.
   function automatic int ref_class(input int x, input int w, input bit c, input bit z);
      int mask = (1 << w) - 1;
      for (int n = 0; n < w; n++) begin
         int code = (1 << n) - 1;
         if (n == 0 && !z) continue;
         if (x == code) return 256 + n;
         if (c && x == (mask & ~code)) return 256 + 128 + n;
      end
      return 0;
   endfunction

   function automatic logic [7:0] rnd_vec();
      int n = $urandom_range(0, 7);
      logic [7:0] code = 8'((1 << n) - 1);
      case ($urandom_range(0, 3))
         0:       return 8'($urandom);
         1:       return code;
         2:       return ~code;
         default: return code ^ 8'(1 << $urandom_range(0, 7));
      endcase
   endfunction

   // Group A: W=8, complimented admitted, zero rejected
   logic        a_rst = 1'b1, a_v = 1'b0, a_rdy = 1'b1, a_clr = 1'b0;
   logic [7:0]  a_x = '0;
   logic        a_ordy, a_ov, a_u, a_c;
   logic [2:0]  a_n;
   logic [15:0] a_acc, a_rej;

   p_stream #(.W(8), .P_ADMIT_COMPLIMENT_EN(1'b1), .P_ADMIT_ZERO_EN(1'b0), .P_CNT_W(16)) u_a (
      .i_clk(clk), .i_arst(a_rst), .i_valid(a_v), .o_ready(a_ordy), .i_x(a_x),
      .o_valid(a_ov), .i_ready(a_rdy), .o_is_unary(a_u), .o_is_compliment(a_c), .o_n(a_n),
      .i_cnt_clr(a_clr), .o_accept_cnt(a_acc), .o_reject_cnt(a_rej));

   // Group B: W=8, complimented rejected, zero admitted, 2-bit counters
   logic       rst = 1'b1, b_v = 1'b0, b_rdy = 1'b1, b_clr = 1'b0;
   logic [7:0] b_x = '0;
   logic       b_ordy, b_ov, b_u, b_c;
   logic [2:0] b_n;
   logic [1:0] b_acc, b_rej;

   p_stream #(.W(8), .P_ADMIT_COMPLIMENT_EN(1'b0), .P_ADMIT_ZERO_EN(1'b1), .P_CNT_W(2)) u_b (
      .i_clk(clk), .i_arst(rst), .i_valid(b_v), .o_ready(b_ordy), .i_x(b_x),
      .o_valid(b_ov), .i_ready(b_rdy), .o_is_unary(b_u), .o_is_compliment(b_c), .o_n(b_n),
      .i_cnt_clr(b_clr), .o_accept_cnt(b_acc), .o_reject_cnt(b_rej));

   // Sweep group: W=6, all four admit combinations sharing one stimulus
   logic        s_v = 1'b0, s_rdy = 1'b1, s_clr = 1'b0;
   logic [5:0]  s_x = '0;
   logic        s_ordy [4];
   logic        s_ov   [4];
   logic        s_u    [4];
   logic        s_c    [4];
   logic [2:0]  s_n    [4];
   logic [15:0] s_acc  [4];
   logic [15:0] s_rej  [4];

   for (genvar g = 0; g < 4; g++) begin : g_sweep
      p_stream #(.W(6), .P_ADMIT_COMPLIMENT_EN((g % 2) == 1), .P_ADMIT_ZERO_EN(g >= 2), .P_CNT_W(16)) u_s (
         .i_clk(clk), .i_arst(rst), .i_valid(s_v), .o_ready(s_ordy[g]), .i_x(s_x),
         .o_valid(s_ov[g]), .i_ready(s_rdy), .o_is_unary(s_u[g]), .o_is_compliment(s_c[g]),
         .o_n(s_n[g]), .i_cnt_clr(s_clr), .o_accept_cnt(s_acc[g]), .o_reject_cnt(s_rej[g]));
   end

   // Scoreboard for group A: vectors in flight and expected statistics
   int a_q [$];
   int a_m_acc = 0;
   int a_m_rej = 0;

   always @(negedge clk) begin
      int r;
      bit xf;
      if (a_rst) begin
         a_q.delete();
         a_m_acc = 0;
         a_m_rej = 0;
      end else begin
         chk("a_acc_cnt", 32'(a_acc), a_m_acc);
         chk("a_rej_cnt", 32'(a_rej), a_m_rej);
         chk("a_o_ready", a_ordy, (a_q.size() == 2 && !a_rdy) ? 0 : 1);
         xf = 1'b0;
         r  = 0;
         if (a_ov && a_rdy) begin
            if (a_q.size() == 0) begin
               chk("a_spurious_out", 1, 0);
            end else begin
               r  = ref_class(a_q.pop_front(), 8, 1'b1, 1'b0);
               xf = 1'b1;
               chk("a_unary", a_u, r[8]);
               chk("a_comp", a_c, r[7]);
               chk("a_n", a_n, r[3:0]);
            end
         end
         if (a_v && a_ordy) a_q.push_back(int'(a_x));
         if (a_clr) begin
            a_m_acc = 0;
            a_m_rej = 0;
         end else if (xf) begin
            if (r[8]) a_m_acc = (a_m_acc == 65535) ? 65535 : a_m_acc + 1;
            else      a_m_rej = (a_m_rej == 65535) ? 65535 : a_m_rej + 1;
         end
      end
   end

   task automatic a_put(input logic [7:0] x);
      bit ok = 1'b0;
      a_x = x;
      a_v = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (a_ordy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("a_put_timeout", 0, 1);
      @(posedge clk);
      #1;
      a_v = 1'b0;
   endtask

   bit a_done;
   int r;
   int s_exp_acc [4];
   logic [7:0] bvec [4];
   bit found;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bvec = '{8'h00, 8'h7F, 8'hFF, 8'h80};
      for (int g = 0; g < 4; g++) s_exp_acc[g] = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_o_valid", a_ov, 0);
      chk("rst_o_ready", a_ordy, 1);
      chk("rst_unary", a_u, 0);
      chk("rst_comp", a_c, 0);
      chk("rst_n", a_n, 0);
      chk("rst_acc", a_acc, 0);
      chk("rst_rej", a_rej, 0);
      a_rst = 1'b0;
      rst   = 1'b0;

      // Back-to-back mixed stream
      a_put(8'h07);
      a_put(8'hF8);
      a_put(8'h00);
      a_put(8'h05);
      repeat (4) @(posedge clk);
      #1;
      chk("p1_acc", a_acc, 2);
      chk("p1_rej", a_rej, 2);

      // Backpressure: two vectors fill the pipe, third waits
      a_rdy = 1'b0;
      a_put(8'h1F);
      a_put(8'hF0);
      a_x = 8'h33;
      a_v = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         r = ref_class(32'h1F, 8, 1'b1, 1'b0);
         chk("bp_o_ready", a_ordy, 0);
         chk("bp_o_valid", a_ov, 1);
         chk("bp_frozen_unary", a_u, r[8]);
         chk("bp_frozen_n", a_n, r[3:0]);
      end
      a_rdy = 1'b1;
      a_put(8'h33);
      repeat (4) @(posedge clk);
      #1;
      chk("bp_drain", a_q.size(), 0);

      // Random stream under random backpressure and occasional clears
      a_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) a_put(rnd_vec());
            a_done = 1'b1;
         end
         begin
            while (!a_done) begin
               @(posedge clk);
               #1;
               a_rdy = ($urandom_range(0, 3) != 0);
               a_clr = ($urandom_range(0, 39) == 0);
            end
         end
      join
      a_rdy = 1'b1;
      a_clr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rnd_drain", a_q.size(), 0);

      // Reset while both stages hold vectors
      a_rdy = 1'b0;
      a_put(8'h03);
      a_put(8'hFC);
      #2;
      a_rst = 1'b1;
      #1;
      chk("arst_o_valid", a_ov, 0);
      chk("arst_o_ready", a_ordy, 1);
      @(posedge clk);
      #1;
      a_rst = 1'b0;
      a_rdy = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("arst_no_output", a_ov, 0);
      end
      chk("arst_acc", a_acc, 0);
      chk("arst_rej", a_rej, 0);

      // Group B: zero admitted, complimented rejected; consecutive results
      for (int k = 0; k <= 4; k++) begin
         if (k < 4) begin
            b_v = 1'b1;
            b_x = bvec[k];
         end else begin
            b_v = 1'b0;
         end
         @(posedge clk);
         #1;
         if (k >= 1) begin
            r = ref_class(int'(bvec[k-1]), 8, 1'b0, 1'b1);
            chk("b_o_valid", b_ov, 1);
            chk("b_unary", b_u, r[8]);
            chk("b_comp", b_c, r[7]);
            chk("b_n", b_n, r[3:0]);
         end
      end
      repeat (2) @(posedge clk);
      #1;
      chk("b_acc", b_acc, 2);
      chk("b_rej", b_rej, 2);

      // Saturation of the 2-bit reject counter
      b_x = 8'h05;
      b_v = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      b_v = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("b_rej_sat", b_rej, 3);
      chk("b_acc_hold", b_acc, 2);

      // Clear coinciding with an accepted transfer
      b_x = 8'h00;
      b_v = 1'b1;
      @(posedge clk);
      #1;
      b_v = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (b_ov) begin
            found = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("b_clr_result_seen", found, 1);
      chk("b_clr_result_unary", b_u, 1);
      b_clr = 1'b1;
      @(posedge clk);
      #1;
      b_clr = 1'b0;
      chk("b_clr_acc", b_acc, 0);
      chk("b_clr_rej", b_rej, 0);
      @(posedge clk);
      #1;
      chk("b_clr_acc_after", b_acc, 0);
      chk("b_clr_o_valid", b_ov, 0);

      // Exhaustive W=6 sweep across all admit combinations
      for (int k = 0; k <= 64; k++) begin
         if (k < 64) begin
            s_v = 1'b1;
            s_x = 6'(k);
         end else begin
            s_v = 1'b0;
         end
         @(posedge clk);
         #1;
         if (k >= 1) begin
            for (int g = 0; g < 4; g++) begin
               r = ref_class(k - 1, 6, (g % 2) == 1, g >= 2);
               if (r[8]) s_exp_acc[g]++;
               chk($sformatf("s%0d_o_valid", g), s_ov[g], 1);
               chk($sformatf("s%0d_o_ready", g), s_ordy[g], 1);
               chk($sformatf("s%0d_unary_x%0d", g, k - 1), s_u[g], r[8]);
               chk($sformatf("s%0d_comp_x%0d", g, k - 1), s_c[g], r[7]);
               chk($sformatf("s%0d_n_x%0d", g, k - 1), s_n[g], r[3:0]);
            end
         end
      end
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("s%0d_acc", g), s_acc[g], s_exp_acc[g]);
         chk($sformatf("s%0d_rej", g), s_rej[g], 64 - s_exp_acc[g]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
